alu_iterative: RTL and testbench

//  Parametrised execute-stage ALU with a valid/ready handshake and registered outputs.

---
 rtl/alu_iterative.sv | 186 ++++++++++++++++++
 tb/tb_alu_iterative.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/alu_iterative.sv
// Execute-stage ALU: single-cycle logic/arith/compare ops, iterative shift-add MULT and restoring DIV.
// Define ALU_SIGNED_MULDIV_EN to make codes 1000/1010 signed; otherwise they alias the unsigned ops.
module alu_iterative #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       control,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic             zero,
  output logic             div_by_zero,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t          state, state_next;
  logic [CW-1:0]   count;
  logic [WIDTH-1:0] acc_hi, acc_lo, opnd_b, a_orig;
  logic            is_div, b_zero;
  logic            accept, is_mul_op, is_div_op, last_iter;
  logic [WIDTH-1:0] a_in, b_in, simple_res, fin_lo, fin_hi;
  logic [WIDTH:0]  mul_sum, div_shift, div_diff;
`ifdef ALU_SIGNED_MULDIV_EN
  logic            signed_op, neg_q, neg_r;
`endif

  function automatic logic [WIDTH-1:0] alu_simple(input logic [3:0] op,
                                                 input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y);
    logic signed [WIDTH-1:0] sx, sy;
    logic [WIDTH-1:0] r;
    sx = x;
    sy = y;
    case (op)
      4'b0000: r = x & y;
      4'b0001: r = x | y;
      4'b0010: r = x + y;
      4'b0110: r = x - y;
      4'b0111: r = {{(WIDTH-1){1'b0}}, (sx < sy)};
      4'b0011: r = x ^ y;
      4'b0100: r = ~(x | y);
      4'b0101: r = {{(WIDTH-1){1'b0}}, (x < y)};
      default: r = '0;
    endcase
    return r;
  endfunction

`ifdef ALU_SIGNED_MULDIV_EN
  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? (~x + 1'b1) : x;
  endfunction
`endif

  assign accept    = in_valid && in_ready;
  assign is_mul_op = (control[3:1] == 3'b100);
  assign is_div_op = (control[3:1] == 3'b101);
  assign last_iter = (count == CW'(WIDTH-1));
  assign simple_res = alu_simple(control, a, b);

  // Operand conditioning at accept: magnitudes for signed ops
  always_comb begin
    a_in = a;
    b_in = b;
`ifdef ALU_SIGNED_MULDIV_EN
    signed_op = !control[0] && (is_mul_op || is_div_op);
    if (signed_op) begin
      a_in = abs_val(a);
      b_in = abs_val(b);
    end
`endif
  end

  // One iteration of each algorithm; acc_lo holds multiplier / dividend bits being consumed
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_b} : {(WIDTH+1){1'b0}});
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_b};
  end

  // Final sign fix-up and divide-by-zero override applied while in DONE
  always_comb begin
    fin_lo = acc_lo;
    fin_hi = acc_hi;
`ifdef ALU_SIGNED_MULDIV_EN
    if (is_div) begin
      if (neg_q) fin_lo = ~acc_lo + 1'b1;
      if (neg_r) fin_hi = ~acc_hi + 1'b1;
    end else if (neg_q) begin
      {fin_hi, fin_lo} = ~{acc_hi, acc_lo} + 1'b1;
    end
`endif
    if (is_div && b_zero) begin
      fin_lo = '1;
      fin_hi = a_orig;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept && is_mul_op) state_next = MUL;
            else if (accept && is_div_op) state_next = DIV;
      MUL:  if (last_iter) state_next = DONE;
      DIV:  if (last_iter) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign in_ready = (state == IDLE);
  assign busy     = !in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_next;
      if (accept) count <= '0;
      else if (state == MUL || state == DIV) count <= count + CW'(1);
    end
  end

  // Iteration datapath: loaded at accept, stepped once per cycle in MUL/DIV
  always_ff @(posedge clk) begin
    if (accept) begin
      acc_hi <= '0;
      acc_lo <= a_in;
      opnd_b <= b_in;
      a_orig <= a;
      is_div <= is_div_op;
      b_zero <= (b == '0);
`ifdef ALU_SIGNED_MULDIV_EN
      neg_q  <= signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
      neg_r  <= signed_op && a[WIDTH-1];
`endif
    end else if (state == MUL) begin
      acc_hi <= mul_sum[WIDTH:1];
      acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
    end else if (state == DIV) begin
      if (!div_diff[WIDTH]) begin
        acc_hi <= div_diff[WIDTH-1:0];
        acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
      end else begin
        acc_hi <= div_shift[WIDTH-1:0];
        acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
      end
    end
  end

  // Registered outputs; held between out_valid pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid   <= 1'b0;
      result      <= '0;
      hi          <= '0;
      zero        <= 1'b1;
      div_by_zero <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (accept && !is_mul_op && !is_div_op) begin
        out_valid   <= 1'b1;
        result      <= simple_res;
        hi          <= '0;
        zero        <= (simple_res == '0);
        div_by_zero <= 1'b0;
      end else if (state == DONE) begin
        out_valid   <= 1'b1;
        result      <= fin_lo;
        hi          <= fin_hi;
        zero        <= (fin_lo == '0);
        div_by_zero <= is_div && b_zero;
      end
    end
  end

endmodule

// File: tb/tb_alu_iterative.sv
// Directed-vector bench for alu_iterative at WIDTH=32; expectations follow ALU_SIGNED_MULDIV_EN.
module tb_alu_iterative;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, out_valid, zero, div_by_zero, busy;
  logic [31:0] a, b, result, hi;
  logic [3:0]  control;
  int          vectors = 0;
  int          miscompares = 0;
  int          lat;
  logic        rdy_low;

  alu_iterative #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .control(control), .out_valid(out_valid), .result(result),
    .hi(hi), .zero(zero), .div_by_zero(div_by_zero), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic one_cycle(input string tag, input logic [3:0] op,
                           input logic [31:0] x, input logic [31:0] y,
                           input logic [31:0] exp);
    control = op; a = x; b = y; in_valid = 1'b1;
    step();
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_result"}, 64'(result), 64'(exp));
  endtask

  // Issue a MULT/DIV, scramble the inputs, then wait (bounded) for the result pulse
  task automatic run_iter(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    control = op; a = x; b = y; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    a = $urandom; b = $urandom; control = 4'($urandom);
    lat = 0;
    rdy_low = 1'b1;
    while (!out_valid && lat < 64) begin
      if (in_ready !== 1'b0 || busy !== 1'b1) rdy_low = 1'b0;
      step();
      lat++;
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; control = '0;
    step(); step();
    reset = 1'b0;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_zero", 64'(zero), 64'd1);
    check("rst_dbz", 64'(div_by_zero), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);

    one_cycle("sub_5_5", 4'b0110, 32'd5, 32'd5, 32'd0);
    check("sub_zero", 64'(zero), 64'd1);
    check("sub_hi", 64'(hi), 64'd0);

    one_cycle("add_wrap", 4'b0010, 32'hFFFF_FFFF, 32'd1, 32'd0);
    one_cycle("slt_m1_1", 4'b0111, 32'hFFFF_FFFF, 32'd1, 32'd1);
    one_cycle("sltu_m1_1", 4'b0101, 32'hFFFF_FFFF, 32'd1, 32'd0);
    check("sltu_zero", 64'(zero), 64'd1);
    one_cycle("and", 4'b0000, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200);
    one_cycle("or", 4'b0001, 32'hF000_0001, 32'h0000_0F10, 32'hF000_0F11);
    one_cycle("xor", 4'b0011, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555);
    one_cycle("nor", 4'b0100, 32'hFFFF_0000, 32'h0000_00FF, 32'h0000_FF00);
    check("nor_zero", 64'(zero), 64'd0);
    one_cycle("sub_neg", 4'b0110, 32'd3, 32'd5, 32'hFFFF_FFFE);
    one_cycle("bad_code", 4'b1111, 32'd7, 32'd9, 32'd0);

    in_valid = 1'b0;
    one_cycle("add_3_4", 4'b0010, 32'd3, 32'd4, 32'd7);
    in_valid = 1'b0;
    step();
    check("hold_valid", 64'(out_valid), 64'd0);
    check("hold_result", 64'(result), 64'd7);

    run_iter(4'b1001, 32'hFFFF_FFFF, 32'd2);
    check("multu_latency", 64'(lat), 64'd33);
    check("multu_busy", 64'(rdy_low), 64'd1);
    check("multu_prod", {hi, result}, 64'h0000_0001_FFFF_FFFE);
    check("multu_ready_after", 64'(in_ready), 64'd1);
    step();
    check("multu_pulse_len", 64'(out_valid), 64'd0);

    run_iter(4'b1010, 32'hFFFF_FFF9, 32'd2);
    check("div_m7_2_latency", 64'(lat), 64'd33);
`ifdef ALU_SIGNED_MULDIV_EN
    check("div_m7_2", {hi, result}, 64'hFFFF_FFFF_FFFF_FFFD);
`else
    check("div_m7_2", {hi, result}, 64'h0000_0001_7FFF_FFFC);
`endif

    run_iter(4'b1010, 32'd7, 32'hFFFF_FFFE);
`ifdef ALU_SIGNED_MULDIV_EN
    check("div_7_m2", {hi, result}, 64'h0000_0001_FFFF_FFFD);
`else
    check("div_7_m2", {hi, result}, 64'h0000_0007_0000_0000);
`endif

    run_iter(4'b1011, 32'd9, 32'd0);
    check("divu_by0_latency", 64'(lat), 64'd33);
    check("divu_by0", {hi, result}, 64'h0000_0009_FFFF_FFFF);
    check("divu_by0_flag", 64'(div_by_zero), 64'd1);
    check("divu_by0_zero", 64'(zero), 64'd0);

    run_iter(4'b1010, 32'h8000_0000, 32'hFFFF_FFFF);
`ifdef ALU_SIGNED_MULDIV_EN
    check("div_minneg", {hi, result}, 64'h0000_0000_8000_0000);
`else
    check("div_minneg", {hi, result}, 64'h8000_0000_0000_0000);
`endif
    check("div_minneg_flag", 64'(div_by_zero), 64'd0);

    run_iter(4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
`ifdef ALU_SIGNED_MULDIV_EN
    check("mult_m1_m1", {hi, result}, 64'h0000_0000_0000_0001);
`else
    check("mult_m1_m1", {hi, result}, 64'hFFFF_FFFE_0000_0001);
`endif

    run_iter(4'b1000, 32'hFFFF_FFFD, 32'd5);
`ifdef ALU_SIGNED_MULDIV_EN
    check("mult_m3_5", {hi, result}, 64'hFFFF_FFFF_FFFF_FFF1);
`else
    check("mult_m3_5", {hi, result}, 64'h0000_0004_FFFF_FFF1);
`endif

    run_iter(4'b1001, 32'h1234_5678, 32'h0001_0000);
    check("multu_shift16", {hi, result}, 64'h0000_1234_5678_0000);

    // Abort a MULT part-way through with reset
    control = 4'b1000; a = 32'd6; b = 32'd7; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_in_ready", 64'(in_ready), 64'd1);
    check("abort_result", 64'(result), 64'd0);
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (out_valid !== 1'b0) lat++;
    end
    check("abort_no_pulse", 64'(lat), 64'd0);
    one_cycle("post_abort_add", 4'b0010, 32'd100, 32'd23, 32'd123);
    in_valid = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
